// File: rtl/gpio_cmd_bridge.sv
// gpio_cmd_bridge: converts the slow CPU GPIO bus {w_clk, data, addr} into
// single-cycle register-write / command strobes and latches read-back data.
module gpio_cmd_bridge #(
  parameter int          PAIR_TIMEOUT = 1024,
  parameter int          RD_TIMEOUT   = 64,
  parameter logic [31:0] RD_TO_VALUE  = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] gpio_in,
  output logic [31:0] gpio_out_bus,
  output logic        wr_valid,
  output logic [15:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        cmd_valid,
  output logic [15:0] cmd_addr,
  output logic [7:0]  cmd_data,
  input  logic        rd_valid,
  input  logic [31:0] rd_data,
  output logic [3:0]  status
);

  localparam int MAX_TO = (PAIR_TIMEOUT > RD_TIMEOUT) ? PAIR_TIMEOUT : RD_TIMEOUT;
  localparam int TW     = $clog2(MAX_TO) + 1;
  // Timers count from 0; the last cycle of the window is TIMEOUT-1.
  localparam logic [TW-1:0] PAIR_LAST = TW'(PAIR_TIMEOUT - 1);
  localparam logic [TW-1:0] RD_LAST   = TW'(RD_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, HAVE_HI, WAIT_RD} state_t;

  state_t        state, state_nxt;
  logic          s0, s1, s2;
  logic          ev;
  logic [15:0]   ev_addr;
  logic [7:0]    ev_data;
  logic [TW-1:0] timer, timer_nxt;
  logic [15:0]   hi_addr, hi_addr_nxt;
  logic [7:0]    hi_byte, hi_byte_nxt;
  logic          ovr_err, ovr_err_nxt;
  logic          rd_to_err, rd_to_err_nxt;
  logic          pair_err, pair_err_nxt;
  logic          from_idle;
  logic [31:0]   out_nxt;
  logic          wr_valid_nxt, cmd_valid_nxt;
  logic [15:0]   wr_addr_nxt, wr_data_nxt, cmd_addr_nxt;
  logic [7:0]    cmd_data_nxt;
  logic          unused_hi;

  // Upper GPIO bits carry nothing for this block.
  assign unused_hi = ^gpio_in[31:25];

  // One event per w_clk rise; addr/data are stable while w_clk is high.
  assign ev      = s1 & ~s2;
  assign ev_addr = gpio_in[15:0];
  assign ev_data = gpio_in[23:16];

  assign status = {ovr_err, rd_to_err, pair_err, (state != IDLE)};

  // Three-flop synchroniser for the host write clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s0 <= gpio_in[24];
      s1 <= s0;
      s2 <= s1;
    end
  end

  // State, timer, pending byte, sticky errors and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      timer        <= '0;
      hi_addr      <= '0;
      hi_byte      <= '0;
      ovr_err      <= 1'b0;
      rd_to_err    <= 1'b0;
      pair_err     <= 1'b0;
      gpio_out_bus <= '0;
      wr_valid     <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      cmd_valid    <= 1'b0;
      cmd_addr     <= '0;
      cmd_data     <= '0;
    end else begin
      state        <= state_nxt;
      timer        <= timer_nxt;
      hi_addr      <= hi_addr_nxt;
      hi_byte      <= hi_byte_nxt;
      ovr_err      <= ovr_err_nxt;
      rd_to_err    <= rd_to_err_nxt;
      pair_err     <= pair_err_nxt;
      gpio_out_bus <= out_nxt;
      wr_valid     <= wr_valid_nxt;
      wr_addr      <= wr_addr_nxt;
      wr_data      <= wr_data_nxt;
      cmd_valid    <= cmd_valid_nxt;
      cmd_addr     <= cmd_addr_nxt;
      cmd_data     <= cmd_data_nxt;
    end
  end

  // Next-state: pairing, command issue, read completion and timeouts.
  always_comb begin
    state_nxt     = state;
    timer_nxt     = timer;
    hi_addr_nxt   = hi_addr;
    hi_byte_nxt   = hi_byte;
    ovr_err_nxt   = ovr_err;
    rd_to_err_nxt = rd_to_err;
    pair_err_nxt  = pair_err;
    out_nxt       = gpio_out_bus;
    wr_valid_nxt  = 1'b0;
    wr_addr_nxt   = wr_addr;
    wr_data_nxt   = wr_data;
    cmd_valid_nxt = 1'b0;
    cmd_addr_nxt  = cmd_addr;
    cmd_data_nxt  = cmd_data;
    from_idle     = 1'b0;

    unique case (state)
      IDLE: from_idle = ev;
      HAVE_HI: begin
        if (ev) begin
          if (ev_addr == hi_addr) begin
            wr_valid_nxt = 1'b1;
            wr_addr_nxt  = hi_addr;
            wr_data_nxt  = {hi_byte, ev_data};
            state_nxt    = IDLE;
          end else begin
            // Unpaired MSB is dropped; the new event is treated as fresh.
            pair_err_nxt = 1'b1;
            from_idle    = 1'b1;
          end
        end else if (timer >= PAIR_LAST) begin
          pair_err_nxt = 1'b1;
          state_nxt    = IDLE;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      WAIT_RD: begin
        // Host events while a read is outstanding are lost.
        if (ev) ovr_err_nxt = 1'b1;
        if (rd_valid) begin
          out_nxt   = rd_data;
          state_nxt = IDLE;
        end else if (timer >= RD_LAST) begin
          out_nxt       = RD_TO_VALUE;
          rd_to_err_nxt = 1'b1;
          state_nxt     = IDLE;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (from_idle) begin
      if (!ev_addr[15]) begin
        hi_addr_nxt = ev_addr;
        hi_byte_nxt = ev_data;
        timer_nxt   = '0;
        state_nxt   = HAVE_HI;
      end else if (ev_addr == 16'hFFFF) begin
        ovr_err_nxt   = 1'b0;
        rd_to_err_nxt = 1'b0;
        pair_err_nxt  = 1'b0;
        state_nxt     = IDLE;
      end else begin
        cmd_valid_nxt = 1'b1;
        cmd_addr_nxt  = ev_addr;
        cmd_data_nxt  = ev_data;
        timer_nxt     = '0;
        state_nxt     = WAIT_RD;
      end
    end
  end

endmodule
